// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV64 execute stage: single-cycle ALU, branch resolve, iterative shift-add MUL/MULHU.
module ex_stage #(
    parameter int XLEN       = 64,
    parameter int MUL_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_in,
    input  logic            flush,
    input  logic            aluSRC,
    input  logic            branch,
    input  logic            memRead,
    input  logic            memWrite,
    input  logic            memToReg,
    input  logic            regWrite,
    input  logic [4:0]      wrReg,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  logic [XLEN-1:0] inme,
    input  logic [1:0]      aluOp,
    input  logic [2:0]      fun3,
    input  logic [6:0]      fun7,
    output logic            stall,
    output logic            valid_out,
    output logic [XLEN-1:0] aluResult,
    output logic [XLEN-1:0] storeData,
    output logic [XLEN-1:0] branchTarget,
    output logic            branchTaken,
    output logic [4:0]      wrReg_out,
    output logic            memRead_out,
    output logic            memWrite_out,
    output logic            memToReg_out,
    output logic            regWrite_out
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int SW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(MUL_CYCLES - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] mcand_q, mplier_q, hi_q;
    logic            mul_hi_q;

    logic            valid_q, taken_q, mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q;
    logic [XLEN-1:0] result_q, store_q, target_q;
    logic [4:0]      wr_reg_q;

    logic [XLEN-1:0] op_b, alu_res, sra_res, wr_result, hi_d, mplier_d, mul_result;
    logic [XLEN:0]   mul_sum;
    logic [SW-1:0]   shamt;
    logic            is_mul, mul_iter, last_iter, start_mul, wr_en, cond;

    assign op_b      = aluSRC ? inme : reg2;
    assign shamt     = op_b[SW-1:0];
    assign sra_res   = $signed(reg1) >>> shamt;
    assign is_mul    = (aluOp == 2'b10) && !aluSRC && (fun7 == 7'b0000001);
    // Only MUL and MULHU go through the iterative unit; other M-encodings retire as 0
    assign mul_iter  = is_mul && ((fun3 == 3'b000) || (fun3 == 3'b011));
    assign last_iter = (state_q == S_MUL) && (cnt_q == LAST_CNT);
    assign stall     = reset_n && valid_in && mul_iter && !flush && !last_iter;
    assign start_mul = (state_q == S_IDLE) && valid_in && !flush && mul_iter;
    assign wr_en     = !flush && (((state_q == S_IDLE) && valid_in && !mul_iter) || last_iter);

    // One shift-add step: {c,hi} = hi + addend, then {c,hi,mplier} >> 1
    assign mul_sum    = {1'b0, hi_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign hi_d       = mul_sum[XLEN:1];
    assign mplier_d   = {mul_sum[0], mplier_q[XLEN-1:1]};
    assign mul_result = mul_hi_q ? hi_d : mplier_d;
    assign wr_result  = last_iter ? mul_result : alu_res;

    always_comb begin
        alu_res = '0;
        cond    = 1'b0;
        case (aluOp)
            2'b00: alu_res = reg1 + op_b;
            2'b01: begin
                alu_res = reg1 - op_b;
                case (fun3)
                    3'b000:  cond = (reg1 == op_b);
                    3'b001:  cond = (reg1 != op_b);
                    3'b100:  cond = ($signed(reg1) <  $signed(op_b));
                    3'b101:  cond = ($signed(reg1) >= $signed(op_b));
                    3'b110:  cond = (reg1 <  op_b);
                    3'b111:  cond = (reg1 >= op_b);
                    default: cond = 1'b0;
                endcase
            end
            2'b10: begin
                if (!is_mul) begin
                    case (fun3)
                        3'b000:  alu_res = (fun7[5] && !aluSRC) ? reg1 - op_b : reg1 + op_b;
                        3'b001:  alu_res = reg1 << shamt;
                        3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(reg1) < $signed(op_b)};
                        3'b011:  alu_res = {{(XLEN-1){1'b0}}, reg1 < op_b};
                        3'b100:  alu_res = reg1 ^ op_b;
                        3'b101:  alu_res = fun7[5] ? sra_res : reg1 >> shamt;
                        3'b110:  alu_res = reg1 | op_b;
                        default: alu_res = reg1 & op_b;
                    endcase
                end
            end
            default: alu_res = op_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            hi_q         <= '0;
            mul_hi_q     <= 1'b0;
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            result_q     <= '0;
            store_q      <= '0;
            target_q     <= '0;
            wr_reg_q     <= '0;
        end else begin
            if (state_q == S_IDLE) begin
                if (start_mul) begin
                    state_q  <= S_MUL;
                    cnt_q    <= '0;
                    mcand_q  <= reg1;
                    mplier_q <= reg2;
                    hi_q     <= '0;
                    mul_hi_q <= (fun3 == 3'b011);
                end
            end else if (flush) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                hi_q     <= hi_d;
                mplier_q <= mplier_d;
                if (last_iter) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            valid_q     <= wr_en;
            taken_q     <= wr_en && branch && cond;
            mem_read_q  <= wr_en && memRead;
            mem_write_q <= wr_en && memWrite;
            reg_write_q <= wr_en && regWrite;
            if (wr_en) begin
                result_q     <= wr_result;
                store_q      <= reg2;
                target_q     <= pc + inme;
                wr_reg_q     <= wrReg;
                mem_to_reg_q <= memToReg;
            end
        end
    end

    assign valid_out    = valid_q;
    assign aluResult    = result_q;
    assign storeData    = store_q;
    assign branchTarget = target_q;
    assign branchTaken  = taken_q;
    assign wrReg_out    = wr_reg_q;
    assign memRead_out  = mem_read_q;
    assign memWrite_out = mem_write_q;
    assign memToReg_out = mem_to_reg_q;
    assign regWrite_out = reg_write_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against a behavioural model.
module tb_ex_stage;
    localparam int MUL_CYCLES = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n, valid_in, flush, aluSRC, branch, memRead, memWrite, memToReg, regWrite;
    logic [4:0]  wrReg;
    logic [63:0] pc, reg1, reg2, inme;
    logic [1:0]  aluOp;
    logic [2:0]  fun3;
    logic [6:0]  fun7;
    logic        stall, valid_out, branchTaken, memRead_out, memWrite_out, memToReg_out, regWrite_out;
    logic [63:0] aluResult, storeData, branchTarget;
    logic [4:0]  wrReg_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(64), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .flush(flush), .aluSRC(aluSRC),
        .branch(branch), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
        .regWrite(regWrite), .wrReg(wrReg), .pc(pc), .reg1(reg1), .reg2(reg2), .inme(inme),
        .aluOp(aluOp), .fun3(fun3), .fun7(fun7), .stall(stall), .valid_out(valid_out),
        .aluResult(aluResult), .storeData(storeData), .branchTarget(branchTarget),
        .branchTaken(branchTaken), .wrReg_out(wrReg_out), .memRead_out(memRead_out),
        .memWrite_out(memWrite_out), .memToReg_out(memToReg_out), .regWrite_out(regWrite_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic src,
                                               input logic [63:0] a, input logic [63:0] r2,
                                               input logic [63:0] imm);
        logic [63:0] b;
        logic signed [63:0] sa;
        logic [127:0] p;
        int sh;
        b  = src ? imm : r2;
        sh = int'(b[5:0]);
        sa = a;
        p  = {64'd0, a} * {64'd0, b};
        if (op == 2'd0) return a + b;
        if (op == 2'd1) return a - b;
        if (op == 2'd3) return b;
        if (!src && f7 == 7'd1) return (f3 == 3'd0) ? p[63:0] : ((f3 == 3'd3) ? p[127:64] : 64'd0);
        case (f3)
            3'd0:    return (f7[5] && !src) ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return (sa < $signed(b)) ? 64'd1 : 64'd0;
            3'd3:    return (a < b) ? 64'd1 : 64'd0;
            3'd4:    return a ^ b;
            3'd5:    return f7[5] ? 64'(sa >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [1:0] op, input logic [2:0] f3, input logic br,
                                       input logic [63:0] a, input logic [63:0] b);
        if (op != 2'd1 || !br) return 1'b0;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return ONES;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic is_multi();
        return aluOp == 2'd2 && !aluSRC && fun7 == 7'd1 && (fun3 == 3'd0 || fun3 == 3'd3);
    endfunction

    task automatic set_instr(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic src, input logic br, input logic [63:0] p,
                             input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm);
        valid_in = 1'b1; flush = 1'b0;
        aluOp = op; fun3 = f3; fun7 = f7; aluSRC = src; branch = br;
        pc = p; reg1 = a; reg2 = b; inme = imm;
        wrReg = 5'($urandom); regWrite = 1'b1; memRead = $urandom_range(0, 1);
        memWrite = $urandom_range(0, 1); memToReg = $urandom_range(0, 1);
    endtask

    task automatic rand_instr();
        logic [6:0] f7;
        logic [1:0] op;
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        op = 2'($urandom);
        set_instr(op, 3'($urandom), f7, 1'($urandom), (op == 2'd1) ? 1'($urandom) : 1'b0,
                  rand64(), rand64(), rand64(), rand64());
        regWrite = $urandom_range(0, 1);
    endtask

    task automatic check_zero();
        check("zero_stall", stall, 0);
        check("zero_valid", valid_out, 0);
        check("zero_result", aluResult, 0);
        check("zero_store", storeData, 0);
        check("zero_target", branchTarget, 0);
        check("zero_taken", branchTaken, 0);
        check("zero_wrreg", wrReg_out, 0);
        check("zero_ctrl", {memRead_out, memWrite_out, memToReg_out, regWrite_out}, 0);
    endtask

    task automatic check_bubble();
        check("bubble_valid", valid_out, 0);
        check("bubble_ctrl", {branchTaken, memRead_out, memWrite_out, regWrite_out}, 0);
    endtask

    task automatic check_accept();
        check("acc_valid", valid_out, 1);
        check("acc_result", aluResult, ref_result(aluOp, fun3, fun7, aluSRC, reg1, reg2, inme));
        check("acc_store", storeData, reg2);
        check("acc_target", branchTarget, pc + inme);
        check("acc_taken", branchTaken, ref_taken(aluOp, fun3, branch, reg1, aluSRC ? inme : reg2));
        check("acc_wrreg", wrReg_out, wrReg);
        check("acc_ctrl", {memRead_out, memWrite_out, memToReg_out, regWrite_out},
              {memRead, memWrite, memToReg, regWrite});
    endtask

    task automatic run_alu();
        #1 check("alu_stall", stall, 0);
        @(posedge clk); @(negedge clk);
        check_accept();
    endtask

    // abort_at = edge index (from presentation) at which flush/reset is applied; -1 = none
    task automatic run_mul(input int abort_at, input bit use_reset);
        for (int c = 0; c <= MUL_CYCLES; c++) begin
            if (c == abort_at) begin
                if (use_reset) reset_n = 1'b0; else flush = 1'b1;
                #1 check("abort_stall", stall, 0);
                @(posedge clk); @(negedge clk);
                check("abort_valid", valid_out, 0);
                check("abort_regwrite", regWrite_out, 0);
                if (use_reset) check_zero();
                reset_n = 1'b1; flush = 1'b0; valid_in = 1'b0;
                for (int k = 0; k < MUL_CYCLES + 4; k++) begin
                    @(posedge clk); @(negedge clk);
                    check("post_abort_valid", valid_out, 0);
                end
                return;
            end
            #1 check("mul_stall", stall, (c < MUL_CYCLES));
            @(posedge clk); @(negedge clk);
            if (c < MUL_CYCLES) begin
                check("mul_busy_valid", valid_out, 0);
                check("mul_busy_regwrite", regWrite_out, 0);
            end else begin
                check_accept();
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        rand_instr();
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            check_zero();
        end
        reset_n = 1'b1;
        set_instr(2'd0, 3'd0, 7'd0, 1'b1, 1'b0, 64'h40, 64'd5, 64'd9, 64'd7);
        run_alu();
        check("first_add", aluResult, 64'd12);

        set_instr(2'd2, 3'd0, 7'h00, 1'b0, 1'b0, 64'h0, ONES, 64'd1, 64'd0);
        run_alu(); check("sweep_add", aluResult, 64'd0);
        set_instr(2'd2, 3'd0, 7'h20, 1'b0, 1'b0, 64'h0, ONES, 64'd1, 64'd0);
        run_alu(); check("sweep_sub", aluResult, 64'hFFFF_FFFF_FFFF_FFFE);
        set_instr(2'd2, 3'd2, 7'h00, 1'b0, 1'b0, 64'h0, ONES, 64'd1, 64'd0);
        run_alu(); check("sweep_slt", aluResult, 64'd1);
        set_instr(2'd2, 3'd3, 7'h00, 1'b0, 1'b0, 64'h0, ONES, 64'd1, 64'd0);
        run_alu(); check("sweep_sltu", aluResult, 64'd0);
        set_instr(2'd2, 3'd5, 7'h20, 1'b0, 1'b0, 64'h0, ONES, 64'd4, 64'd0);
        run_alu(); check("sweep_sra", aluResult, ONES);

        set_instr(2'd1, 3'd4, 7'h00, 1'b0, 1'b1, 64'h100, ONES, 64'd1, 64'h20);
        run_alu(); check("blt_taken", branchTaken, 1); check("blt_target", branchTarget, 64'h120);
        set_instr(2'd1, 3'd6, 7'h00, 1'b0, 1'b1, 64'h100, ONES, 64'd1, 64'h20);
        run_alu(); check("bltu_taken", branchTaken, 0);

        set_instr(2'd2, 3'd0, 7'h01, 1'b0, 1'b0, 64'h0, ONES, 64'd2, 64'd0);
        run_mul(-1, 1'b0); check("mul_lo", aluResult, 64'hFFFF_FFFF_FFFF_FFFE);
        set_instr(2'd2, 3'd3, 7'h01, 1'b0, 1'b0, 64'h0, ONES, 64'd2, 64'd0);
        run_mul(-1, 1'b0); check("mulhu", aluResult, 64'd1);

        set_instr(2'd2, 3'd0, 7'h01, 1'b0, 1'b0, 64'h0, ONES, 64'd3, 64'd0);
        run_mul(31, 1'b0);
        set_instr(2'd0, 3'd0, 7'd0, 1'b0, 1'b0, 64'h0, 64'd100, 64'd23, 64'd0);
        run_alu(); check("post_flush_add", aluResult, 64'd123);

        set_instr(2'd2, 3'd3, 7'h01, 1'b0, 1'b0, 64'h0, ONES, ONES, 64'd0);
        run_mul(11, 1'b1);
        set_instr(2'd0, 3'd0, 7'd0, 1'b1, 1'b0, 64'h0, 64'd1, 64'd0, 64'd2);
        run_alu(); check("post_reset_add", aluResult, 64'd3);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0: begin
                    valid_in = 1'b0;
                    @(posedge clk); @(negedge clk);
                    check_bubble();
                end
                1: begin
                    rand_instr();
                    if (is_multi()) fun7 = 7'h00;
                    flush = 1'b1;
                    #1 check("flush_stall", stall, 0);
                    @(posedge clk); @(negedge clk);
                    check_bubble();
                    flush = 1'b0;
                end
                2: begin
                    set_instr(2'd2, ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd0, 7'h01, 1'b0, 1'b0,
                              rand64(), rand64(), rand64(), rand64());
                    run_mul(-1, 1'b0);
                end
                default: begin
                    rand_instr();
                    if (is_multi()) run_mul(-1, 1'b0);
                    else run_alu();
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV64 pipeline.
- Consumes the ID/EX pipeline register outputs: control bits, PC, two register operands, immediate, ALU op, funct3, funct7.
- Performs single-cycle ALU operations, branch compare/target generation, and an iterative 64-cycle MUL/MULHU.
- Registers all results into EX/MEM outputs.
- Asserts stall upstream while a multiply is in progress.

Parameters:
XLEN, 64, datapath width
MUL_CYCLES, 64, shift-add iterations per multiply (equals XLEN)

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  synchronous active-low reset
valid_in  in  1  ID/EX holds a live instruction
flush  in  1  kill the instruction in EX (branch redirect)
aluSRC  in  1  1 = operand B is imm, 0 = reg2
branch, memRead, memWrite, memToReg, regWrite  in  1 each  control from ID/EX
wrReg  in  5  destination register
pc, reg1, reg2, inme  in  64 each  PC, rs1 value, rs2 value, immediate (byte offset)
aluOp  in  2  00 add, 01 branch, 10 R/I-type, 11 pass B
fun3  in  3  funct3
fun7  in  7  funct7
stall  out  1  combinational; 1 = upstream must hold IF/ID and ID/EX
valid_out  out  1  EX/MEM holds a live instruction
aluResult  out  64  result / memory address
storeData  out  64  registered reg2
branchTarget  out  64  pc + inme
branchTaken  out  1  branch condition true and branch=1
wrReg_out  out  5  destination
memRead_out, memWrite_out, memToReg_out, regWrite_out  out  1 each  forwarded control

Behaviour:
- Reset (reset_n=0 at edge): all outputs 0, FSM to IDLE, counter 0, product regs 0. Overrides flush and valid_in.
- Operand B = aluSRC ? inme : reg2.
- Accept occurs when valid_in=1, flush=0, stall=0. On accept the EX/MEM outputs update at that edge, giving latency 1.
- When no accept occurs: valid_out=0, and branchTaken, memRead_out, memWrite_out, regWrite_out are 0 (bubble). Data outputs are don't-care but hold their previous value.
- aluOp 00: A+B.
- aluOp 11: B.
- aluOp 01: result A-B. Condition by fun3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 never taken. branchTaken = branch & cond.
- aluOp 10 by fun3:
  - 000: add; sub if fun7[5]=1 and aluSRC=0.
  - 001: sll.
  - 010: slt (signed).
  - 011: sltu.
  - 100: xor.
  - 101: srl; sra if fun7[5]=1.
  - 110: or.
  - 111: and.
  - Shift amount = B[5:0]. Arithmetic wraps mod 2^64.
- is_mul = aluOp 10 & aluSRC=0 & fun7=0000001.
  - fun3 000 = MUL (low 64 bits of unsigned product).
  - fun3 011 = MULHU (high 64 bits).
  - Any other fun3 with is_mul = single-cycle, result 0.
- FSM IDLE/MUL.
  - IDLE, valid_in & is_mul & !flush: latch mcand=reg1, mplier=reg2, hi=0, cnt=0 → MUL. No EX/MEM update (bubble).
  - MUL, each cycle: {c,hi} = hi + (mplier[0] ? mcand : 0); then {hi,mplier} = {c,hi,mplier} >> 1; cnt++.
  - On the cycle cnt=MUL_CYCLES-1: the final iteration's result is written to EX/MEM with valid_out=1 and wrReg/control from the held ID/EX; FSM → IDLE.
- stall = valid_in & is_mul & !flush & !(state=MUL & cnt=MUL_CYCLES-1).
  - A multiply therefore occupies EX for 65 cycles: 1 accept + 64 iterate, with stall high for the first 64 and low in the last.
  - Its result appears 65 edges after first presentation.
- flush=1: no accept this edge (bubble out). In MUL, FSM aborts to IDLE, cnt=0, stall drops the same cycle, and no result is written.
- Upstream holds ID/EX stable while stall=1. Operands are re-read from latched copies only.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with valid_in=1 and random inputs → all outputs 0, stall 0. Release → first add produces valid_out 1 edge later.
- ALU sweep: reg1=0xFFFF_FFFF_FFFF_FFFF, reg2=1, aluOp=10, aluSRC=0.
  - fun3=000 fun7=0 → aluResult 0.
  - fun7=0100000 → 0xFFFF_FFFF_FFFF_FFFE.
  - fun3=010 → 1.
  - fun3=011 → 0.
  - fun3=101 fun7=0100000, reg2=4 → all ones.
- Branch: pc=0x100, inme=0x20, reg1=-1, reg2=1, branch=1, aluOp=01.
  - fun3=100 → branchTaken=1, branchTarget=0x120.
  - fun3=110 → branchTaken=0.
- MUL/MULHU: reg1=0xFFFF_FFFF_FFFF_FFFF, reg2=2.
  - fun3=000 → stall high 64 cycles, then aluResult=0xFFFF_FFFF_FFFF_FFFE, valid_out=1 at edge 65.
  - fun3=011 → aluResult=1.
  - Check valid_out=0 and regWrite_out=0 throughout the stall.
- Flush mid-multiply: start MUL, assert flush at cnt=30 → stall low that cycle, valid_out stays 0, next add accepted normally.
- Reset mid-multiply: reset_n=0 at cnt=10 → FSM IDLE, outputs 0, no stale result appears after release.
